// File: rtl/pipe_io_responder.sv
// Memory-mapped board I/O responder on the MEM-stage data bus (256-byte window at IO_BASE).
// Optional macro HEX_DECODE_EN: hex digits held as nibbles and decoded to segments internally.
module pipe_io_responder #(
    parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic [9:0]  sw,
    input  logic [2:0]  key,
    output logic [9:0]  led,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [5:0] R_SW     = 6'd0;
    localparam logic [5:0] R_KEYLVL = 6'd1;
    localparam logic [5:0] R_KEYEDG = 6'd2;
    localparam logic [5:0] R_LED    = 6'd3;
    localparam logic [5:0] R_HEXLO  = 6'd4;
    localparam logic [5:0] R_HEXHI  = 6'd5;
    localparam logic [5:0] R_CYCLE  = 6'd6;

    logic [5:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;
    logic        unused_addr_lsb;

    logic [9:0]  sw_meta_q, sw_sync_q;
    logic [2:0]  key_meta_q, key_sync_q;
    logic [2:0]  key_db_q, key_db_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [2:0]  press;
    logic [2:0]  edg_clr;
    logic [2:0]  edg_q, edg_d;
    logic [9:0]  led_q, led_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] hexlo_rd, hexhi_rd;

    assign hit             = (addr[31:8] == IO_BASE[31:8]);
    assign reg_sel         = addr[7:2];
    assign wr_en           = we & hit;
    assign rd_en           = re & hit;
    assign unused_addr_lsb = ^addr[1:0];
    assign led             = led_q;

    // Debounce: key_db is 1 = pressed, so the stable raw level is ~key_db.
    always_comb begin
        key_db_d = key_db_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (key_sync_q[i] == ~key_db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                key_db_d[i] = ~key_sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign press = key_db_d & ~key_db_q;

    always_comb begin
        edg_clr = '0;
        if (rd_en && reg_sel == R_KEYEDG) edg_clr = 3'b111;
        if (wr_en && reg_sel == R_KEYEDG) edg_clr = edg_clr | wdata[2:0];
        edg_d = (edg_q & ~edg_clr) | press;
        led_d = (wr_en && reg_sel == R_LED) ? wdata[9:0] : led_q;
        cyc_d = (wr_en && reg_sel == R_CYCLE) ? wdata + 32'd1 : cyc_q + 32'd1;
    end

`ifdef HEX_DECODE_EN
    logic [23:0] nib_q, nib_d;
    logic        hexv_q, hexv_d;

    function automatic logic [6:0] seg_font(input logic [3:0] n);
        case (n)
            4'h0: seg_font = 7'h40;  4'h1: seg_font = 7'h79;
            4'h2: seg_font = 7'h24;  4'h3: seg_font = 7'h30;
            4'h4: seg_font = 7'h19;  4'h5: seg_font = 7'h12;
            4'h6: seg_font = 7'h02;  4'h7: seg_font = 7'h78;
            4'h8: seg_font = 7'h00;  4'h9: seg_font = 7'h10;
            4'hA: seg_font = 7'h08;  4'hB: seg_font = 7'h03;
            4'hC: seg_font = 7'h46;  4'hD: seg_font = 7'h21;
            4'hE: seg_font = 7'h06;  default: seg_font = 7'h0E;
        endcase
    endfunction

    always_comb begin
        nib_d  = nib_q;
        hexv_d = hexv_q;
        if (wr_en && reg_sel == R_HEXLO) begin
            nib_d  = wdata[23:0];
            hexv_d = 1'b1;
        end
    end

    // Displays stay blank until the first HEXLO write after reset.
    assign hex0     = hexv_q ? seg_font(nib_q[3:0])   : 7'h7F;
    assign hex1     = hexv_q ? seg_font(nib_q[7:4])   : 7'h7F;
    assign hex2     = hexv_q ? seg_font(nib_q[11:8])  : 7'h7F;
    assign hex3     = hexv_q ? seg_font(nib_q[15:12]) : 7'h7F;
    assign hex4     = hexv_q ? seg_font(nib_q[19:16]) : 7'h7F;
    assign hex5     = hexv_q ? seg_font(nib_q[23:20]) : 7'h7F;
    assign hexlo_rd = {8'b0, nib_q};
    assign hexhi_rd = '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            nib_q  <= '0;
            hexv_q <= 1'b0;
        end else begin
            nib_q  <= nib_d;
            hexv_q <= hexv_d;
        end
    end
`else
    logic [5:0][6:0] hex_q, hex_d;

    always_comb begin
        hex_d = hex_q;
        if (wr_en && reg_sel == R_HEXLO) begin
            hex_d[0] = wdata[6:0];
            hex_d[1] = wdata[14:8];
            hex_d[2] = wdata[22:16];
            hex_d[3] = wdata[30:24];
        end
        if (wr_en && reg_sel == R_HEXHI) begin
            hex_d[4] = wdata[6:0];
            hex_d[5] = wdata[14:8];
        end
    end

    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign hex4     = hex_q[4];
    assign hex5     = hex_q[5];
    assign hexlo_rd = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
    assign hexhi_rd = {16'b0, 1'b0, hex_q[5], 1'b0, hex_q[4]};

    always_ff @(posedge clock) begin
        if (reset) hex_q <= {6{7'h7F}};
        else       hex_q <= hex_d;
    end
`endif

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (reg_sel)
                R_SW:     rdata = {22'b0, sw_sync_q};
                R_KEYLVL: rdata = {29'b0, key_db_q};
                R_KEYEDG: rdata = {29'b0, edg_q};
                R_LED:    rdata = {22'b0, led_q};
                R_HEXLO:  rdata = hexlo_rd;
                R_HEXHI:  rdata = hexhi_rd;
                R_CYCLE:  rdata = cyc_q;
                default:  rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= 3'b111;
            key_sync_q <= 3'b111;
            key_db_q   <= '0;
            cnt_q      <= '0;
            edg_q      <= '0;
            led_q      <= '0;
            cyc_q      <= '0;
        end else begin
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= key;
            key_sync_q <= key_meta_q;
            key_db_q   <= key_db_d;
            cnt_q      <= cnt_d;
            edg_q      <= edg_d;
            led_q      <= led_d;
            cyc_q      <= cyc_d;
        end
    end

endmodule

// File: tb/tb_pipe_io_responder.sv
// Bench for pipe_io_responder: reset, directed multi-cycle sequences, a vector table,
// and randomized bus/pin activity against a behavioural model of the register map.
module tb_pipe_io_responder;
    localparam int DEB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        we, re, hit;
    logic [9:0]  sw, led;
    logic [2:0]  key;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    always #5 clock = ~clock;

    pipe_io_responder #(.IO_BASE(32'hFFFF_FF00), .DEBOUNCE_CYCLES(DEB)) dut (
        .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .hit(hit), .sw(sw), .key(key), .led(led),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0]  m_led;
    logic [31:0] m_cyc;
    logic [2:0]  m_db, m_edg;
    logic [6:0]  m_hex [6];
    logic [23:0] m_nib;
    logic        m_hexv;
    logic [9:0]  m_swq [$];
    logic [2:0]  m_keyq [$];
    logic [2:0]  m_syncq [$];

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return f[n];
    endfunction

    function automatic logic [9:0] m_sw_sync();
        return (m_swq.size() >= 2) ? m_swq[0] : 10'h0;
    endfunction

    function automatic logic [2:0] m_key_sync();
        return (m_keyq.size() >= 2) ? m_keyq[0] : 3'b111;
    endfunction

    function automatic logic [41:0] m_hex_word();
        logic [41:0] w;
        for (int i = 0; i < 6; i++) begin
`ifdef HEX_DECODE_EN
            w[7*i +: 7] = m_hexv ? font(m_nib[4*i +: 4]) : 7'h7F;
`else
            w[7*i +: 7] = m_hex[i];
`endif
        end
        return w;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:8] != 24'hFFFFFF) return 32'h0;
        case (a[7:2])
            6'd0: return {22'b0, m_sw_sync()};
            6'd1: return {29'b0, m_db};
            6'd2: return {29'b0, m_edg};
            6'd3: return {22'b0, m_led};
`ifdef HEX_DECODE_EN
            6'd4: return {8'b0, m_nib};
            6'd5: return 32'h0;
`else
            6'd4: return {1'b0, m_hex[3], 1'b0, m_hex[2], 1'b0, m_hex[1], 1'b0, m_hex[0]};
            6'd5: return {16'b0, 1'b0, m_hex[5], 1'b0, m_hex[4]};
`endif
            6'd6: return m_cyc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic       h;
        logic [5:0] sel;
        logic [2:0] press, clr;
        bit         all;
        if (reset) begin
            m_led = '0; m_cyc = '0; m_db = '0; m_edg = '0; m_nib = '0; m_hexv = 1'b0;
            for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
            m_swq.delete(); m_keyq.delete(); m_syncq.delete();
            return;
        end
        h   = (addr[31:8] == 24'hFFFFFF);
        sel = addr[7:2];
        // A key level is accepted once the synced pin has shown the opposite level for DEB edges in a row.
        m_syncq.push_back(m_key_sync());
        if (m_syncq.size() > DEB) void'(m_syncq.pop_front());
        press = '0;
        if (m_syncq.size() == DEB) begin
            for (int i = 0; i < 3; i++) begin
                all = 1;
                foreach (m_syncq[j]) if (m_syncq[j][i] != m_db[i]) all = 0;
                if (all) begin
                    m_db[i] = ~m_db[i];
                    if (m_db[i]) press[i] = 1'b1;
                end
            end
        end
        clr = '0;
        if (h && sel == 6'd2 && re) clr = 3'b111;
        if (h && sel == 6'd2 && we) clr = clr | wdata[2:0];
        m_edg = (m_edg & ~clr) | press;
        if (h && we) begin
            case (sel)
                6'd3: m_led = wdata[9:0];
`ifdef HEX_DECODE_EN
                6'd4: begin m_nib = wdata[23:0]; m_hexv = 1'b1; end
`else
                6'd4: begin
                    m_hex[0] = wdata[6:0];   m_hex[1] = wdata[14:8];
                    m_hex[2] = wdata[22:16]; m_hex[3] = wdata[30:24];
                end
                6'd5: begin m_hex[4] = wdata[6:0]; m_hex[5] = wdata[14:8]; end
`endif
                default: ;
            endcase
        end
        m_cyc = (h && we && sel == 6'd6) ? wdata + 32'd1 : m_cyc + 32'd1;
        m_swq.push_back(sw);
        if (m_swq.size() > 2) void'(m_swq.pop_front());
        m_keyq.push_back(key);
        if (m_keyq.size() > 2) void'(m_keyq.pop_front());
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic check_model();
        check("hit", hit, (addr[31:8] == 24'hFFFFFF));
        check("rdata", rdata, m_read(addr));
        check("led", led, m_led);
        check("hex", {hex5, hex4, hex3, hex2, hex1, hex0}, m_hex_word());
    endtask

    task automatic rd(input logic [31:0] a);
        we = 0; re = 1; addr = a; #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
        logic        exp_hit;
    } vec_t;
    vec_t tbl [$];

    function automatic void add(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic chk, input logic [31:0] exp, input logic eh);
        vec_t v;
        v.a = a; v.w = w; v.d = d; v.chk = chk; v.exp = exp; v.exp_hit = eh;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_hexlo, exp_hexhi;
        logic [41:0] exp_hex;
        reset = 1; addr = 0; wdata = 0; we = 0; re = 0; sw = 10'h2A5; key = 3'b111;
        @(negedge clock);
        step(); step();
        reset = 0;

        // reset state
        addr = 32'h0; #1;
        check("rst_hit", hit, 1'b0);
        check("rst_rdata_nohit", rdata, 32'h0);
        check("rst_led", led, 10'h0);
        check("rst_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h7F}});
        rd(32'hFFFF_FF18);
        check("rst_cycle", rdata, 32'd0);
        step(); rd(32'hFFFF_FF18);
        check("cycle_1", rdata, 32'd1);

        // switch synchroniser latency
        step(); rd(32'hFFFF_FF00);
        check("sw_hit", hit, 1'b1);
        check("sw_2a5", rdata, 32'h2A5);
        sw = 10'h15A;
        step(); rd(32'hFFFF_FF00);
        check("sw_lat1", rdata, 32'h2A5);
        step(); rd(32'hFFFF_FF00);
        check("sw_lat2", rdata, 32'h15A);
        rd(32'hFFFF_FF40);
        check("unmapped_hit", hit, 1'b1);
        check("unmapped_rd", rdata, 32'h0);

        // bouncing KEY1 never accepted, then steady press accepted DEB edges after sync
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                key = (k < 2) ? 3'b110 : 3'b111;
                step(); rd(32'hFFFF_FF04);
                check("bounce_lvl", rdata, 32'h0);
            end
        end
        key = 3'b110;
        for (int k = 1; k <= 6; k++) begin
            step(); rd(32'hFFFF_FF04);
            check("press_lvl", rdata, (k >= 6) ? 32'h1 : 32'h0);
        end
        rd(32'hFFFF_FF08);
        check("edg_first", rdata, 32'h1);
        step(); rd(32'hFFFF_FF08);
        check("edg_cleared", rdata, 32'h0);

        // KEY2 press lands on the same edge as a KEYEDG read: set wins
        re = 0; addr = 32'hFFFF_FF0C; key = 3'b100;
        for (int k = 0; k < 5; k++) step();
        rd(32'hFFFF_FF08);
        check("edg_race_old", rdata, 32'h0);
        step(); re = 0; #1;
        check("edg_race_kept", rdata, 32'h2);
        we = 1; wdata = 32'h2; step(); we = 0; #1;
        check("edg_w1c", rdata, 32'h0);
        rd(32'hFFFF_FF04);
        check("keylvl_both", rdata, 32'h3);
        key = 3'b111; re = 0;
        for (int k = 0; k < 8; k++) step();
        rd(32'hFFFF_FF04);
        check("release_lvl", rdata, 32'h0);
        rd(32'hFFFF_FF08);
        check("release_no_edg", rdata, 32'h0);

        // cycle counter load and wrap
        re = 0; we = 1; addr = 32'hFFFF_FF18; wdata = 32'hFFFF_FFFE; step();
        rd(32'hFFFF_FF18);
        check("cyc_load", rdata, 32'hFFFF_FFFF);
        step(); #1;
        check("cyc_wrap", rdata, 32'h0);
        step(); #1;
        check("cyc_after_wrap", rdata, 32'h1);

`ifdef HEX_DECODE_EN
        exp_hexlo = 32'h0000_1234; exp_hexhi = 32'h0;
        exp_hex   = {7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
`else
        exp_hexlo = 32'h2B00_1234; exp_hexhi = 32'h0000_5678;
        exp_hex   = {7'h56, 7'h78, 7'h2B, 7'h00, 7'h12, 7'h34};
`endif
        add(32'h0000_0000, 0, 32'h0,         1, 32'h0,     0);
        add(32'hFFFF_FF00, 0, 32'h0,         1, 32'h15A,   1);
        add(32'hFFFF_FF40, 0, 32'h0,         1, 32'h0,     1);
        add(32'hFFFF_FF0C, 1, 32'h0000_03FF, 0, 32'h0,     1);
        add(32'hFFFF_FF0C, 0, 32'h0,         1, 32'h3FF,   1);
        add(32'hFFFF_FF0F, 0, 32'h0,         1, 32'h3FF,   1);
        add(32'h0000_000C, 1, 32'h0,         1, 32'h0,     0);
        add(32'hFFFF_FF0C, 0, 32'h0,         1, 32'h3FF,   1);
        add(32'hFFFF_FF10, 1, 32'hAB00_1234, 0, 32'h0,     1);
        add(32'hFFFF_FF10, 0, 32'h0,         1, exp_hexlo, 1);
        add(32'hFFFF_FF14, 1, 32'hABCD_5678, 0, 32'h0,     1);
        add(32'hFFFF_FF14, 0, 32'h0,         1, exp_hexhi, 1);
        add(32'hFFFF_FF1C, 1, 32'hFFFF_FFFF, 0, 32'h0,     1);
        add(32'hFFFF_FF1C, 0, 32'h0,         1, 32'h0,     1);
        add(32'hFFFF_FF04, 0, 32'h0,         1, 32'h0,     1);
        add(32'hFFFF_FF0C, 1, 32'h0000_0155, 0, 32'h0,     1);
        add(32'hFFFF_FF0C, 0, 32'h0,         1, 32'h155,   1);
        foreach (tbl[i]) begin
            addr = tbl[i].a; we = tbl[i].w; re = ~tbl[i].w; wdata = tbl[i].d; #1;
            check($sformatf("tbl%0d_hit", i), hit, tbl[i].exp_hit);
            if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp);
            step();
        end
        we = 0; re = 0; #1;
        check("tbl_led_port", led, 10'h155);
        check("tbl_hex_ports", {hex5, hex4, hex3, hex2, hex1, hex0}, exp_hex);

        // randomized bus and pin activity against the model
        for (int n = 0; n < 3000; n++) begin
            int op;
            reset = (n == 1500 || n == 1501);
            if ($urandom_range(0, 7) == 0) begin
                int b = $urandom_range(0, 2);
                key[b] = ~key[b];
            end
            if ($urandom_range(0, 31) == 0) sw = 10'($urandom);
            if ($urandom_range(0, 3) != 0)
                addr = {24'hFFFFFF, 6'($urandom_range(0, 9)), 2'($urandom_range(0, 3))};
            else
                addr = $urandom;
            op = $urandom_range(0, 3);
            we = (op == 0);
            re = (op == 1 || op == 2);
            wdata = $urandom;
            #1;
            check_model();
            step();
        end
        reset = 0; we = 0; re = 0; #1;
        check_model();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
